// File: rtl/boot_loader_if.sv
// Boot loader bus bundle: ROM read port on one side, SRAM target write
// ports on the other. The loader is the master of both.
interface boot_loader_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 17,
  parameter int NUM_TARGETS = 3
) ();
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic                   rom_n_oe;
  logic [DATA_WIDTH-1:0]  rom_data;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  data;
  logic [NUM_TARGETS-1:0] n_we;

  modport master (
    output rom_addr, rom_n_oe, addr, data, n_we,
    input  rom_data
  );

  modport slave (
    input  rom_addr, rom_n_oe, addr, data, n_we,
    output rom_data
  );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: copies length-programmable regions from a fixed-latency ROM
// into NUM_TARGETS SRAM targets, verifying a per-target additive checksum.
// Every output is a flop so strobes and enables are glitch-free.
module boot_loader #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 17,
  parameter int NUM_TARGETS  = 3,
  parameter int READ_LATENCY = 2,
  localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [NUM_TARGETS*ADDR_WIDTH-1:0] target_len,
  boot_loader_if.master                     bus,
  output logic                              n_booted,
  output logic                              busy,
  output logic                              error,
  output logic [TW-1:0]                     error_target
);

  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAIL  = 3'd6
  } state_t;

  // Additive checksum step, wraps modulo 2^DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] csum_add(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] word
  );
    return acc + word;
  endfunction

  // Active-low one-hot write strobe for target t.
  function automatic logic [NUM_TARGETS-1:0] strobe_for(input logic [TW-1:0] t);
    logic [NUM_TARGETS-1:0] s;
    s = {NUM_TARGETS{1'b1}};
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (t == TW'(i)) begin
        s[i] = 1'b0;
      end else begin
        s[i] = 1'b1;
      end
    end
    return s;
  endfunction

  state_t                 state_r, state_s;
  logic [TW-1:0]          tgt_r, tgt_s;
  logic [ADDR_WIDTH-1:0]  ptr_r, ptr_s;
  logic [ADDR_WIDTH-1:0]  laddr_r, laddr_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0]  csum_r, csum_s;
  logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
  logic [DATA_WIDTH-1:0]  data_r, data_s;
  logic [NUM_TARGETS-1:0] n_we_r, n_we_s;
  logic                   rom_n_oe_r, rom_n_oe_s;
  logic                   n_booted_r, n_booted_s;
  logic                   busy_r, busy_s;
  logic                   error_r, error_s;
  logic [TW-1:0]          error_target_r, error_target_s;

  logic [ADDR_WIDTH-1:0]  len_s;
  logic                   last_cnt_s;
  logic                   last_tgt_s;

  assign len_s      = target_len[int'(tgt_r)*ADDR_WIDTH +: ADDR_WIDTH];
  assign last_cnt_s = (cnt_r == CW'(READ_LATENCY - 1));
  assign last_tgt_s = (tgt_r == TW'(NUM_TARGETS - 1));

  // ROM_ADDR is the read pointer flop itself; it only moves at capture edges.
  assign bus.rom_addr  = ptr_r;
  assign bus.rom_n_oe  = rom_n_oe_r;
  assign bus.addr      = addr_r;
  assign bus.data      = data_r;
  assign bus.n_we      = n_we_r;
  assign n_booted      = n_booted_r;
  assign busy          = busy_r;
  assign error         = error_r;
  assign error_target  = error_target_r;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so they are registered alongside the state they belong to.
  always_comb begin
    state_s        = state_r;
    tgt_s          = tgt_r;
    ptr_s          = ptr_r;
    laddr_s        = laddr_r;
    cnt_s          = cnt_r;
    csum_s         = csum_r;
    addr_s         = addr_r;
    data_s         = data_r;
    n_we_s         = {NUM_TARGETS{1'b1}};
    rom_n_oe_s     = rom_n_oe_r;
    n_booted_s     = n_booted_r;
    busy_s         = busy_r;
    error_s        = error_r;
    error_target_s = error_target_r;

    case (state_r)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_s    = ST_SETUP;
          tgt_s      = {TW{1'b0}};
          ptr_s      = {ADDR_WIDTH{1'b0}};
          n_booted_s = 1'b1;
          busy_s     = 1'b1;
          error_s    = 1'b0;
          rom_n_oe_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end

      ST_SETUP: begin
        if (len_s == {ADDR_WIDTH{1'b0}}) begin
          // Empty region: consumes no ROM words, just one SETUP cycle.
          if (last_tgt_s) begin
            state_s    = ST_DONE;
            busy_s     = 1'b0;
            n_booted_s = 1'b0;
          end else begin
            tgt_s = tgt_r + TW'(1);
          end
        end else begin
          laddr_s    = {ADDR_WIDTH{1'b0}};
          csum_s     = {DATA_WIDTH{1'b0}};
          cnt_s      = {CW{1'b0}};
          rom_n_oe_s = 1'b0;
          state_s    = ST_READ;
        end
      end

      ST_READ: begin
        if (last_cnt_s) begin
          data_s     = bus.rom_data;
          addr_s     = laddr_r;
          csum_s     = csum_add(csum_r, bus.rom_data);
          ptr_s      = ptr_r + ADDR_WIDTH'(1);
          rom_n_oe_s = 1'b1;
          n_we_s     = strobe_for(tgt_r);
          state_s    = ST_WRITE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end

      ST_WRITE: begin
        laddr_s    = laddr_r + ADDR_WIDTH'(1);
        cnt_s      = {CW{1'b0}};
        rom_n_oe_s = 1'b0;
        if ((laddr_r + ADDR_WIDTH'(1)) == len_s) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_READ;
        end
      end

      ST_CHECK: begin
        if (last_cnt_s) begin
          ptr_s      = ptr_r + ADDR_WIDTH'(1);
          rom_n_oe_s = 1'b1;
          if (bus.rom_data != csum_r) begin
            state_s        = ST_FAIL;
            error_s        = 1'b1;
            error_target_s = tgt_r;
            busy_s         = 1'b0;
            n_booted_s     = 1'b1;
          end else if (last_tgt_s) begin
            state_s    = ST_DONE;
            busy_s     = 1'b0;
            n_booted_s = 1'b0;
          end else begin
            tgt_s   = tgt_r + TW'(1);
            state_s = ST_SETUP;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end

      default: begin
        state_s    = ST_IDLE;
        busy_s     = 1'b0;
        n_booted_s = 1'b1;
        rom_n_oe_s = 1'b1;
      end
    endcase
  end

  // State and output registers; async reset drops strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      tgt_r          <= {TW{1'b0}};
      ptr_r          <= {ADDR_WIDTH{1'b0}};
      laddr_r        <= {ADDR_WIDTH{1'b0}};
      cnt_r          <= {CW{1'b0}};
      csum_r         <= {DATA_WIDTH{1'b0}};
      addr_r         <= {ADDR_WIDTH{1'b0}};
      data_r         <= {DATA_WIDTH{1'b0}};
      n_we_r         <= {NUM_TARGETS{1'b1}};
      rom_n_oe_r     <= 1'b1;
      n_booted_r     <= 1'b1;
      busy_r         <= 1'b0;
      error_r        <= 1'b0;
      error_target_r <= {TW{1'b0}};
    end else begin
      state_r        <= state_s;
      tgt_r          <= tgt_s;
      ptr_r          <= ptr_s;
      laddr_r        <= laddr_s;
      cnt_r          <= cnt_s;
      csum_r         <= csum_s;
      addr_r         <= addr_s;
      data_r         <= data_s;
      n_we_r         <= n_we_s;
      rom_n_oe_r     <= rom_n_oe_s;
      n_booted_r     <= n_booted_s;
      busy_r         <= busy_s;
      error_r        <= error_s;
      error_target_r <= error_target_s;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: a 3-target, latency-2 instance and a
// 16-bit, single-target, latency-1 instance, with ROM models and a write
// scoreboard per instance.
module tb_boot_loader;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Instance A: defaults (8-bit, 3 targets, latency 2)
  logic        start_a;
  logic [50:0] len_a;
  logic        n_booted_a, busy_a, error_a;
  logic [1:0]  et_a;
  boot_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(17), .NUM_TARGETS(3)) bus_a ();

  boot_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(17), .NUM_TARGETS(3), .READ_LATENCY(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .target_len(len_a), .bus(bus_a),
    .n_booted(n_booted_a), .busy(busy_a), .error(error_a), .error_target(et_a)
  );

  // Instance B: 16-bit, 1 target, latency 1
  logic        start_b;
  logic [16:0] len_b;
  logic        n_booted_b, busy_b, error_b;
  logic [0:0]  et_b;
  boot_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(17), .NUM_TARGETS(1)) bus_b ();

  boot_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(17), .NUM_TARGETS(1), .READ_LATENCY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .target_len(len_b), .bus(bus_b),
    .n_booted(n_booted_b), .busy(busy_b), .error(error_b), .error_target(et_b)
  );

  // ROM models
  logic [7:0]  mem_a [32];
  logic [7:0]  rom_q_a;
  logic [15:0] mem_b [8];

  // Latency-2 ROM: one pipeline stage after the address.
  always @(posedge clk) rom_q_a <= mem_a[bus_a.rom_addr[4:0]];
  assign bus_a.rom_data = rom_q_a;
  assign bus_b.rom_data = mem_b[bus_b.rom_addr[2:0]];

  // Scoreboards and counters
  logic [63:0] q_a [$];
  logic [63:0] q_b [$];
  int n_checks = 0;
  int n_errors = 0;
  int busy_tot_a = 0, oe_tot_a = 0, busy_tot_b = 0;
  int base_busy_a, base_oe_a, base_busy_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor A: count busy/OE cycles, compare each write against the scoreboard.
  always @(negedge clk) begin : mon_a
    logic [63:0] e;
    if (busy_a) busy_tot_a++;
    if (bus_a.rom_n_oe == 1'b0) oe_tot_a++;
    if (bus_a.n_we !== 3'b111) begin
      if (q_a.size() == 0) begin
        check("wr_a_unexpected", 64'(bus_a.n_we), 64'h7);
      end else begin
        e = q_a.pop_front();
        check("wr_a", 64'({bus_a.n_we, bus_a.addr, bus_a.data}), e);
      end
    end
  end

  // Monitor B: same for the 16-bit instance.
  always @(negedge clk) begin : mon_b
    logic [63:0] e;
    if (busy_b) busy_tot_b++;
    if (bus_b.n_we !== 1'b1) begin
      if (q_b.size() == 0) begin
        check("wr_b_unexpected", 64'(bus_b.n_we), 64'h1);
      end else begin
        e = q_b.pop_front();
        check("wr_b", 64'({bus_b.n_we, bus_b.addr, bus_b.data}), e);
      end
    end
  end

  // Build ROM image A and push expected writes; bad_t corrupts that checksum.
  task automatic prep_a(input int l0, input int l1, input int l2, input int bad_t);
    int lens [3];
    int ptr;
    bit failed;
    logic [7:0] sum, d;
    logic [2:0] one, nwe;
    lens = '{l0, l1, l2};
    len_a = {17'(l2), 17'(l1), 17'(l0)};
    ptr = 0;
    failed = 1'b0;
    one = 3'b001;
    for (int t = 0; t < 3; t++) begin
      if (lens[t] > 0) begin
        sum = 8'h00;
        nwe = ~(one << t);
        for (int i = 0; i < lens[t]; i++) begin
          d = 8'($urandom);
          mem_a[ptr] = d;
          sum = sum + d;
          if (!failed) q_a.push_back(64'({nwe, 17'(i), d}));
          ptr++;
        end
        mem_a[ptr] = (t == bad_t) ? (sum ^ 8'h01) : sum;
        if (t == bad_t) failed = 1'b1;
        ptr++;
      end
    end
  endtask

  task automatic pulse_a();
    @(negedge clk);
    base_busy_a = busy_tot_a;
    base_oe_a   = oe_tot_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (busy_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("a_timeout", 64'(n < 400), 64'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; len_a = '0; len_b = '0;
    for (int i = 0; i < 32; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem_b[i] = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_a_bus", 64'({bus_a.rom_addr, bus_a.rom_n_oe, bus_a.addr, bus_a.data, bus_a.n_we}),
          64'({17'd0, 1'b1, 17'd0, 8'd0, 3'b111}));
    check("rst_a_stat", 64'({n_booted_a, busy_a, error_a, et_a}), 64'({1'b1, 1'b0, 1'b0, 2'd0}));
    check("rst_b_stat", 64'({bus_b.n_we, n_booted_b, busy_b, error_b}), 64'(4'b1100));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal load {4,0,2}
    prep_a(4, 0, 2, -1);
    pulse_a();
    wait_idle_a();
    check("ok_busy_cycles", 64'(busy_tot_a - base_busy_a), 64'd25);
    check("ok_oe_cycles", 64'(oe_tot_a - base_oe_a), 64'd16);
    check("ok_status", 64'({n_booted_a, error_a}), 64'(2'b00));
    check("ok_q_empty", 64'(q_a.size()), 64'd0);

    // Corrupted checksum of target 2
    prep_a(4, 0, 2, 2);
    pulse_a();
    wait_idle_a();
    check("bad_busy_cycles", 64'(busy_tot_a - base_busy_a), 64'd25);
    check("bad_status", 64'({n_booted_a, busy_a, error_a, et_a}), 64'({1'b1, 1'b0, 1'b1, 2'd2}));
    check("bad_q_empty", 64'(q_a.size()), 64'd0);

    // Restart from FAIL: error clears on start
    prep_a(4, 0, 2, -1);
    pulse_a();
    check("restart_status", 64'({n_booted_a, busy_a, error_a}), 64'(3'b110));
    wait_idle_a();
    check("restart_done", 64'({n_booted_a, error_a}), 64'(2'b00));
    check("restart_q_empty", 64'(q_a.size()), 64'd0);

    // Restart from DONE, with START re-pulsed during READ
    prep_a(4, 0, 2, -1);
    pulse_a();
    check("done_restart_nb", 64'(n_booted_a), 64'd1);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_idle_a();
    check("repulse_busy_cycles", 64'(busy_tot_a - base_busy_a), 64'd25);
    check("repulse_done", 64'(n_booted_a), 64'd0);
    check("repulse_q_empty", 64'(q_a.size()), 64'd0);

    // Reset while a write strobe is low
    prep_a(4, 0, 2, -1);
    pulse_a();
    n = 0;
    while (bus_a.n_we === 3'b111 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_we", 64'(n < 100), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bus", 64'({bus_a.rom_addr, bus_a.rom_n_oe, bus_a.addr, bus_a.data, bus_a.n_we}),
          64'({17'd0, 1'b1, 17'd0, 8'd0, 3'b111}));
    check("midrst_stat", 64'({n_booted_a, busy_a, error_a, et_a}), 64'({1'b1, 1'b0, 1'b0, 2'd0}));
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    base_busy_a = busy_tot_a;
    base_oe_a   = oe_tot_a;
    repeat (10) @(negedge clk);
    check("post_rst_idle", 64'({busy_tot_a - base_busy_a, oe_tot_a - base_oe_a}), 64'd0);
    check("post_rst_nb", 64'(n_booted_a), 64'd1);

    // All lengths zero
    prep_a(0, 0, 0, -1);
    pulse_a();
    wait_idle_a();
    check("zero_busy_cycles", 64'(busy_tot_a - base_busy_a), 64'd3);
    check("zero_oe_cycles", 64'(oe_tot_a - base_oe_a), 64'd0);
    check("zero_done", 64'(n_booted_a), 64'd0);

    // 16-bit, latency 1, checksum wraparound
    len_b = 17'd2;
    mem_b[0] = 16'hFFFF; mem_b[1] = 16'h0002; mem_b[2] = 16'h0001;
    q_b.push_back(64'({1'b0, 17'd0, 16'hFFFF}));
    q_b.push_back(64'({1'b0, 17'd1, 16'h0002}));
    @(negedge clk);
    base_busy_b = busy_tot_b;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (busy_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_timeout", 64'(n < 100), 64'd1);
    check("b_busy_cycles", 64'(busy_tot_b - base_busy_b), 64'd6);
    check("b_status", 64'({n_booted_b, error_b}), 64'(2'b00));
    check("b_q_empty", 64'(q_b.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Parametrised successor to the single-purpose bootstrapper. After a START pulse it copies code and tables from a slow, fixed-latency ROM (EEPROM) into NUM_TARGETS SRAM targets: microcode, MLU slices, MLU lookahead, and any added later. Each target's region is length-programmable and checksum-verified. It sits between the boot ROM and the SRAM write ports and drives the system N_BOOTED flag.

## Interface
- DATA_WIDTH, 8: ROM/target data word width.
- ADDR_WIDTH, 17: ROM and target address width.
- NUM_TARGETS, 3: number of SRAM targets (≥1).
- READ_LATENCY, 2: cycles from ROM_ADDR valid to ROM_DATA valid (≥1).
- TW = max(1, $clog2(NUM_TARGETS)): target index width.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- N_RST  in  1  reset; one clock; reset is asynchronous and active-low.
- START  in  1  begin (or restart) boot; sampled high on a rising edge.
- TARGET_LEN  in  NUM_TARGETS*ADDR_WIDTH  word count per target; target t in bits [t*ADDR_WIDTH +: ADDR_WIDTH]; must be held stable while BUSY.
- ROM_ADDR  out  ADDR_WIDTH  ROM word address.
- ROM_N_OE  out  1  ROM output enable, active low.
- ROM_DATA  in  DATA_WIDTH  ROM read data.
- ADDR  out  ADDR_WIDTH  target-local write address.
- DATA  out  DATA_WIDTH  target write data.
- N_WE  out  NUM_TARGETS  per-target write strobe, active low, at most one low.
- N_BOOTED  out  1  low once all targets are loaded and verified.
- BUSY  out  1  high while loading.
- ERROR  out  1  checksum failure latched.
- ERROR_TARGET  out  TW  index of the failing target.

## Operation
- ROM layout is packed in target order. For each target t with L_t>0: L_t data words, then one checksum word. Targets with L_t=0 consume no ROM words.
- Checksum is the sum mod 2^DATA_WIDTH of the target's data words. The accumulator clears at each target's SETUP.
- States: IDLE, SETUP, READ, WRITE, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL + START goes to SETUP with t=0 and ROM pointer 0. N_BOOTED goes to 1 and ERROR clears. START in SETUP/READ/WRITE/CHECK is ignored.
- SETUP, 1 cycle:
  - if L_t=0: advance t and stay in SETUP, or go to DONE if t was last;
  - else clear local address and checksum, then go to READ.
- READ, READ_LATENCY cycles: ROM_ADDR=pointer, ROM_N_OE=0. The last cycle's edge captures ROM_DATA into DATA, adds it to the checksum, increments the pointer, and goes to WRITE.
- WRITE, 1 cycle: N_WE[t]=0 with ADDR/DATA stable; ROM_N_OE=1. Then increment ADDR; if words written = L_t go to CHECK, else READ.
- CHECK, READ_LATENCY cycles: the checksum word is read as in READ. The last edge compares it with the accumulator and increments the pointer.
  - Mismatch: go to FAIL, ERROR=1, ERROR_TARGET=t.
  - Match: go to SETUP(t+1), or DONE if t is last.
- DONE: N_BOOTED=0, BUSY=0. FAIL: N_BOOTED=1, BUSY=0, ERROR=1. Both hold until START or reset.
- BUSY=1 exactly in SETUP/READ/WRITE/CHECK.
- All TARGET_LEN zero: NUM_TARGETS SETUP cycles, then DONE.

## Timing
- Reset values: IDLE; ROM_ADDR=0, ROM_N_OE=1, ADDR=0, DATA=0, N_WE=all 1, N_BOOTED=1, BUSY=0, ERROR=0, ERROR_TARGET=0.
- Reset asserted mid-operation forces reset values immediately, without waiting for a clock. N_WE deasserts combinationally-from-reset; no partial-cycle write strobe survives. Loading restarts only on a new START.
- N_WE, ROM_N_OE, and all outputs are registered (glitch-free).
- ADDR/DATA change only on the edge ending a WRITE cycle or a READ capture, never while N_WE is low.
- Per non-zero target: 1 + L_t*(READ_LATENCY+1) + READ_LATENCY cycles. Per zero target: 1 cycle.
- BUSY rises on the edge after START is sampled. DONE/FAIL is entered on the edge ending the last CHECK (or the last SETUP).

## Test plan
- NUM_TARGETS=3, READ_LATENCY=2, TARGET_LEN={4,0,2}, valid checksums at ROM 4 and 7:
  - target 0 writes ROM 0..3 to ADDR 0..3;
  - target 1 gets no writes;
  - target 2 writes ROM 5..6 to ADDR 0..1;
  - BUSY high exactly 25 cycles, then N_BOOTED=0.
- Same setup, ROM word 7 corrupted: target 2 data is still written, then ERROR=1, ERROR_TARGET=2, N_BOOTED=1, BUSY=0. START then re-runs the load with ERROR cleared.
- DATA_WIDTH=16, READ_LATENCY=1, one target, L=2, words 0xFFFF, 0x0002, checksum 0x0001: passes (wraparound), total 6 BUSY cycles.
- N_RST pulsed low while N_WE[0]=0 mid-load: N_WE returns to all 1 without a clock, all outputs take reset values, and the block stays in IDLE until START.
- START re-pulsed during READ: ignored, load completes with identical write sequence. START in DONE: N_BOOTED returns to 1 and a full reload occurs.
- All TARGET_LEN=0, NUM_TARGETS=3: BUSY high 3 cycles, no ROM_N_OE low, no writes, N_BOOTED=0.
